// File: rtl/display_stat_latch.sv
// Producer side of the 8-digit BPM/SNR display: smooths BPM over four samples, peak-holds SNR,
// and publishes both at a fixed refresh rate with stale-BPM detection.
module display_stat_latch #(
    parameter int REFRESH_CYCLES = 12_500_000,
    parameter int STALE_PERIODS  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bpm_in,
    input  logic        bpm_valid,
    input  logic [7:0]  snr_in,
    input  logic        snr_valid,
    output logic [11:0] bpm_disp,
    output logic [6:0]  snr_disp,
    output logic        disp_update,
    output logic        bpm_stale
);

    localparam int CW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(REFRESH_CYCLES - 1);
    localparam int SW = $clog2(STALE_PERIODS + 1);
    localparam logic [SW-1:0] STALE_MAX = SW'(STALE_PERIODS);

    logic [CW-1:0] count;
    logic [11:0]   w0, w1, w2, w3;
    logic [13:0]   sum;
    logic          filled;
    logic [6:0]    peak;
    logic          snr_seen;
    logic          bpm_seen;
    logic [SW-1:0] stale_cnt;

    logic [11:0]   bpm_sat;
    logic [6:0]    snr_clip;
    logic [11:0]   avg;
    logic          tick;
    logic          no_bpm;
    logic [SW-1:0] stale_cnt_inc;
    logic          stale_next;

    // snr_in is two's complement: a set sign bit means a negative reading.
    always_comb begin
        bpm_sat       = (bpm_in > 16'd4095) ? 12'hFFF : bpm_in[11:0];
        snr_clip      = snr_in[7] ? 7'd0 : ((snr_in[6:0] > 7'd99) ? 7'd99 : snr_in[6:0]);
        avg           = sum[13:2];
        tick          = (count == COUNT_LAST);
        no_bpm        = !bpm_seen && !bpm_valid;
        stale_cnt_inc = (stale_cnt == STALE_MAX) ? stale_cnt : stale_cnt + 1'b1;
        // Stale is sticky until a sample arrives, so it also survives from reset.
        stale_next    = no_bpm && (bpm_stale || (stale_cnt_inc >= STALE_MAX));
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees
    // pre-edge values, e.g. bpm_disp takes the avg from before a same-cycle sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w0     <= '0;
            w1     <= '0;
            w2     <= '0;
            w3     <= '0;
            sum    <= '0;
            filled <= 1'b0;
        end else if (bpm_valid) begin
            if (!filled) begin
                w0     <= bpm_sat;
                w1     <= bpm_sat;
                w2     <= bpm_sat;
                w3     <= bpm_sat;
                sum    <= {bpm_sat, 2'b00};
                filled <= 1'b1;
            end else begin
                w3  <= w2;
                w2  <= w1;
                w1  <= w0;
                w0  <= bpm_sat;
                sum <= sum - {2'b00, w3} + {2'b00, bpm_sat};
            end
        end else if (tick && stale_next) begin
            // Only the fill flag matters; slot contents are overwritten by the next load.
            filled <= 1'b0;
        end
    end

    // A sample arriving on the tick cycle is carried into the next period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak     <= '0;
            snr_seen <= 1'b0;
        end else if (tick) begin
            peak     <= snr_valid ? snr_clip : 7'd0;
            snr_seen <= snr_valid;
        end else if (snr_valid) begin
            peak     <= (snr_clip > peak) ? snr_clip : peak;
            snr_seen <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bpm_seen  <= 1'b0;
            stale_cnt <= '0;
        end else if (tick) begin
            bpm_seen  <= 1'b0;
            stale_cnt <= no_bpm ? stale_cnt_inc : '0;
        end else if (bpm_valid) begin
            bpm_seen  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bpm_disp    <= '0;
            snr_disp    <= '0;
            disp_update <= 1'b0;
            bpm_stale   <= 1'b1;
        end else begin
            disp_update <= tick;
            if (tick) begin
                bpm_disp  <= stale_next ? 12'd0 : avg;
                bpm_stale <= stale_next;
                if (snr_seen) begin
                    snr_disp <= peak;
                end
            end
        end
    end

endmodule

// File: tb/tb_display_stat_latch.sv
// Directed bench for display_stat_latch: stimulus pushes expected display values, a monitor
// pops and compares them on every disp_update pulse.
module tb_display_stat_latch;

    localparam int REFRESH = 16;
    localparam int STALE   = 2;
    localparam int UPDATE_LIMIT = 3 * REFRESH;

    typedef struct packed {
        logic [11:0] bpm;
        logic [6:0]  snr;
        logic        stale;
    } disp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] bpm_in;
    logic        bpm_valid;
    logic [7:0]  snr_in;
    logic        snr_valid;
    logic [11:0] bpm_disp;
    logic [6:0]  snr_disp;
    logic        disp_update;
    logic        bpm_stale;

    disp_t sb[$];
    int    compared   = 0;
    int    mismatched = 0;
    logic  prev_update = 1'b0;

    display_stat_latch #(
        .REFRESH_CYCLES(REFRESH),
        .STALE_PERIODS (STALE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bpm_in     (bpm_in),
        .bpm_valid  (bpm_valid),
        .snr_in     (snr_in),
        .snr_valid  (snr_valid),
        .bpm_disp   (bpm_disp),
        .snr_disp   (snr_disp),
        .disp_update(disp_update),
        .bpm_stale  (bpm_stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic expect_disp(input int b, input int s, input int st);
        disp_t e;
        e.bpm   = 12'(b);
        e.snr   = 7'(s);
        e.stale = 1'(st);
        sb.push_back(e);
    endtask

    // Returns at the negedge that first shows disp_update, with the number of negedges waited.
    task automatic wait_update(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!disp_update && n < UPDATE_LIMIT);
        if (!disp_update) begin
            compared++;
            mismatched++;
            $display("FAIL update_timeout: no disp_update within %0d clocks", UPDATE_LIMIT);
        end
    endtask

    task automatic next_tick();
        int n;
        wait_update(n);
    endtask

    task automatic bpm_pulse(input logic [15:0] v);
        bpm_in    = v;
        bpm_valid = 1'b1;
        @(negedge clk);
        bpm_valid = 1'b0;
    endtask

    task automatic snr_pulse(input logic [7:0] v);
        snr_in    = v;
        snr_valid = 1'b1;
        @(negedge clk);
        snr_valid = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_bpm_disp"},    int'(bpm_disp),    0);
        check({tag, "_snr_disp"},    int'(snr_disp),    0);
        check({tag, "_bpm_stale"},   int'(bpm_stale),   1);
        check({tag, "_disp_update"}, int'(disp_update), 0);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n && disp_update) begin
            disp_t e;
            check("update_not_back_to_back", int'(prev_update), 0);
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_update: bpm_disp=%0d snr_disp=%0d stale=%0d with no expectation",
                         bpm_disp, snr_disp, bpm_stale);
            end else begin
                e = sb.pop_front();
                check("bpm_disp",  int'(bpm_disp),  int'(e.bpm));
                check("snr_disp",  int'(snr_disp),  int'(e.snr));
                check("bpm_stale", int'(bpm_stale), int'(e.stale));
            end
        end
        prev_update = disp_update;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        bpm_in    = '0;
        bpm_valid = 1'b0;
        snr_in    = '0;
        snr_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");

        // P1: idle period after reset.
        expect_disp(0, 0, 1);
        rst_n = 1'b1;
        wait_update(n);
        check("first_update_latency", n, REFRESH);

        // P2: window fill then shift -> (132+128+124+120)/4.
        expect_disp(126, 0, 0);
        bpm_pulse(16'd120);
        bpm_pulse(16'd124);
        bpm_pulse(16'd128);
        bpm_pulse(16'd132);
        next_tick();

        // P3: BPM saturation and SNR upper clip.
        expect_disp(4095, 99, 0);
        repeat (4) bpm_pulse(16'd5000);
        snr_pulse(8'd120);
        next_tick();

        // P4: negative SNR clips to 0.
        expect_disp(4095, 0, 0);
        bpm_pulse(16'd5000);
        snr_pulse(8'hFB);
        next_tick();

        // P5: peak hold across several samples.
        expect_disp(4095, 40, 0);
        bpm_pulse(16'd5000);
        snr_pulse(8'd10);
        snr_pulse(8'd40);
        snr_pulse(8'd25);
        next_tick();

        // P6: no SNR in period holds 40; SNR 55 lands on the tick cycle.
        expect_disp(4095, 40, 0);
        bpm_pulse(16'd5000);
        repeat (REFRESH - 2) @(negedge clk);
        snr_in    = 8'd55;
        snr_valid = 1'b1;
        next_tick();
        snr_valid = 1'b0;

        // P7: full window replacement back to avg 126; carried SNR 55 appears.
        expect_disp(126, 55, 0);
        bpm_pulse(16'd120);
        bpm_pulse(16'd124);
        bpm_pulse(16'd128);
        bpm_pulse(16'd132);
        next_tick();

        // P8/P9: BPM goes quiet; one more tick of 126, then stale.
        expect_disp(126, 55, 0);
        next_tick();
        expect_disp(0, 55, 1);
        next_tick();

        // P10: window refilled from empty.
        expect_disp(90, 55, 0);
        bpm_pulse(16'd90);
        next_tick();

        // P11: BPM on the tick cycle; display shows the pre-update average.
        expect_disp(90, 55, 0);
        repeat (REFRESH - 1) @(negedge clk);
        bpm_in    = 16'd200;
        bpm_valid = 1'b1;
        next_tick();
        bpm_valid = 1'b0;

        // P12: window 200,90,90,90 -> 470/4 truncated.
        expect_disp(117, 55, 0);
        next_tick();

        // P13: back to 126.
        expect_disp(126, 55, 0);
        repeat (4) bpm_pulse(16'd126);
        next_tick();

        // P14: reset mid-period.
        bpm_pulse(16'd100);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_state("mid_reset");
        repeat (2) @(negedge clk);
        expect_disp(0, 0, 1);
        rst_n = 1'b1;
        wait_update(n);
        check("post_reset_update_latency", n, REFRESH);

        repeat (2) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
